// File: rtl/fifo_rr_drain_scheduler_pkg.sv
// Shared types and default sizing for the round-robin FIFO drain scheduler.
package fifo_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_PRESENT = 2'd3
   } sched_state_t;

   localparam int DEF_NUM_CH    = 4;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_BURST_MAX = 4;

endpackage

// File: rtl/fifo_rr_drain_scheduler_if.sv
// FIFO-bank side and downstream side of the drain scheduler, bundled as one interface.
interface fifo_rr_drain_scheduler_if
   import fifo_sched_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CH_W   = $clog2(NUM_CH)
);
   logic [NUM_CH-1:0]        i_empty;
   logic [NUM_CH*DATA_W-1:0] i_data;
   logic [NUM_CH-1:0]        o_pop;
   logic [DATA_W-1:0]        o_data;
   logic                     o_valid;
   logic                     i_ready;
   logic [CH_W-1:0]          o_ch;

   modport master (
      input  i_empty, i_data, i_ready,
      output o_pop, o_data, o_valid, o_ch
   );

   modport slave (
      output i_empty, i_data, i_ready,
      input  o_pop, o_data, o_valid, o_ch
   );
endinterface

// File: rtl/fifo_rr_drain_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, modulo NUM_CH.
module rr_pick
   import fifo_sched_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [CH_W-1:0]   i_ptr,
   output logic [CH_W-1:0]   o_grant,
   output logic              o_any
);
   logic [CH_W:0]     w_sum [NUM_CH];
   logic [CH_W-1:0]   w_idx [NUM_CH];
   logic [NUM_CH-1:0] w_hit;

   // Candidate gi is ptr+gi folded back into 0..NUM_CH-1 without relying on bit truncation.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign w_sum[gi] = {1'b0, i_ptr} + (CH_W+1)'(gi);
      assign w_idx[gi] = (w_sum[gi] >= (CH_W+1)'(NUM_CH))
                       ? CH_W'(w_sum[gi] - (CH_W+1)'(NUM_CH))
                       : w_sum[gi][CH_W-1:0];
      assign w_hit[gi] = i_req[w_idx[gi]];
   end

   always_comb begin
      o_grant = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            o_grant = w_idx[i];
         end
      end
   end

   assign o_any = |i_req;
endmodule

// File: rtl/fifo_rr_drain_scheduler.sv
// Round-robin drain of NUM_CH channel FIFOs onto one valid/ready port, up to BURST_MAX words per grant.
module fifo_rr_drain_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BURST_MAX = DEF_BURST_MAX,
   parameter int CH_W      = $clog2(NUM_CH),
   parameter int BCNT_W    = $clog2(BURST_MAX + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_enable,
   fifo_rr_drain_scheduler_if.master  bus,
   output logic                       o_busy
);
   sched_state_t      r_state,  w_state_next;
   logic [CH_W-1:0]   r_grant,  w_grant_next;
   logic [CH_W-1:0]   r_rr_ptr, w_rr_ptr_next;
   logic [BCNT_W-1:0] r_bcnt,   w_bcnt_next;
   logic [DATA_W-1:0] r_data,   w_data_next;
   logic              r_valid,  w_valid_next;
   logic [CH_W-1:0]   r_ch,     w_ch_next;

   logic [NUM_CH-1:0] w_req;
   logic [NUM_CH-1:0] w_pop;
   logic [CH_W-1:0]   w_pick;
   logic              w_any;
   logic              w_more;
   logic [CH_W-1:0]   w_ptr_wrap;

   assign w_req = ~bus.i_empty;

   rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
      .i_req   (w_req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick),
      .o_any   (w_any)
   );

   // Empty flag here already reflects the pop issued two cycles ago.
   assign w_more     = (r_bcnt < BCNT_W'(BURST_MAX)) && !bus.i_empty[r_grant] && i_enable;
   assign w_ptr_wrap = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_bcnt   <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_ch     <= '0;
      end else begin
         r_state  <= w_state_next;
         r_grant  <= w_grant_next;
         r_rr_ptr <= w_rr_ptr_next;
         r_bcnt   <= w_bcnt_next;
         r_data   <= w_data_next;
         r_valid  <= w_valid_next;
         r_ch     <= w_ch_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_grant_next  = r_grant;
      w_rr_ptr_next = r_rr_ptr;
      w_bcnt_next   = r_bcnt;
      w_data_next   = r_data;
      w_valid_next  = r_valid;
      w_ch_next     = r_ch;
      w_pop         = '0;

      unique case (r_state)
         ST_IDLE: begin
            if (i_enable && w_any) begin
               w_grant_next = w_pick;
               w_bcnt_next  = '0;
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A channel that emptied under us gets no pop; the pointer is left alone.
            if (!bus.i_empty[r_grant]) begin
               w_pop[r_grant] = 1'b1;
               w_state_next   = ST_CAPTURE;
            end else begin
               w_state_next   = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            w_data_next  = bus.i_data[r_grant*DATA_W +: DATA_W];
            w_ch_next    = r_grant;
            w_valid_next = 1'b1;
            w_bcnt_next  = r_bcnt + 1'b1;
            w_state_next = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (bus.i_ready) begin
               w_valid_next = 1'b0;
               if (w_more) begin
                  w_state_next = ST_ISSUE;
               end else begin
                  w_rr_ptr_next = w_ptr_wrap;
                  w_state_next  = ST_IDLE;
               end
            end
         end
      endcase
   end

   assign bus.o_pop   = w_pop;
   assign bus.o_data  = r_data;
   assign bus.o_valid = r_valid;
   assign bus.o_ch    = r_ch;
   assign o_busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_fifo_rr_drain_scheduler.sv
`timescale 1ns/1ps
// Bench: a 4-channel/burst-4 and a 3-channel/burst-1 scheduler fed by behavioural FIFOs,
// with per-instance scoreboards of expected {channel, word} in drain order.
module tb_fifo_rr_drain_scheduler;
   localparam int DW    = 16;
   localparam int DEPTH = 32;

   typedef struct packed {
      logic [3:0]  ch;
      logic [15:0] data;
   } txn_t;

   typedef struct {
      int          ch;
      logic [15:0] data;
      int          delay;
      int          exp_ch;
      logic [15:0] exp_data;
      int          exp_lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n, en_a, en_b, busy_a, busy_b;
   int   n_checks = 0;
   int   n_fail   = 0;
   txn_t exp_a[$];
   txn_t exp_b[$];

   fifo_rr_drain_scheduler_if #(.NUM_CH(4), .DATA_W(DW)) bus_a ();
   fifo_rr_drain_scheduler_if #(.NUM_CH(3), .DATA_W(DW)) bus_b ();

   fifo_rr_drain_scheduler #(.NUM_CH(4), .DATA_W(DW), .BURST_MAX(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_enable(en_a), .bus(bus_a), .o_busy(busy_a)
   );
   fifo_rr_drain_scheduler #(.NUM_CH(3), .DATA_W(DW), .BURST_MAX(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_enable(en_b), .bus(bus_b), .o_busy(busy_b)
   );

   always #5 clk = ~clk;

   // Behavioural FIFOs: registered read data appears the cycle after a pop.
   logic [15:0] mem_a [4][DEPTH];
   logic [15:0] mem_b [3][DEPTH];
   logic [15:0] rd_a [4];
   logic [15:0] rd_b [3];
   int head_a [4] = '{default: 0};
   int tail_a [4] = '{default: 0};
   int head_b [3] = '{default: 0};
   int tail_b [3] = '{default: 0};

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (bus_a.o_pop[k]) begin
            rd_a[k]   <= mem_a[k][head_a[k] % DEPTH];
            head_a[k] <= head_a[k] + 1;
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (bus_b.o_pop[k]) begin
            rd_b[k]   <= mem_b[k][head_b[k] % DEPTH];
            head_b[k] <= head_b[k] + 1;
         end
      end
   end

   always_comb begin
      bus_a.i_empty = '0;
      bus_a.i_data  = '0;
      bus_b.i_empty = '0;
      bus_b.i_data  = '0;
      for (int k = 0; k < 4; k++) begin
         bus_a.i_empty[k]          = (head_a[k] == tail_a[k]);
         bus_a.i_data[k*DW +: DW]  = rd_a[k];
      end
      for (int k = 0; k < 3; k++) begin
         bus_b.i_empty[k]          = (head_b[k] == tail_b[k]);
         bus_b.i_data[k*DW +: DW]  = rd_b[k];
      end
   end

   function automatic void check(string name, int act, int want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
      end
   endfunction

   function automatic txn_t mk(int ch, int d);
      txn_t t;
      t.ch   = 4'(ch);
      t.data = 16'(d);
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(int ch, int d);
      mem_a[ch][tail_a[ch] % DEPTH] = 16'(d);
      tail_a[ch] = tail_a[ch] + 1;
   endtask

   task automatic load_b(int ch, int d);
      mem_b[ch][tail_b[ch] % DEPTH] = 16'(d);
      tail_b[ch] = tail_b[ch] + 1;
   endtask

   task automatic wait_valid_a(output int k);
      k = 0;
      while (!bus_a.o_valid && k < 40) begin
         tick();
         k++;
      end
   endtask

   task automatic wait_idle_a(string tag);
      int k = 0;
      while ((busy_a || exp_a.size() != 0) && k < 300) begin
         tick();
         k++;
      end
      check(tag, exp_a.size() + int'(busy_a), 0);
   endtask

   task automatic wait_idle_b(string tag);
      int k = 0;
      while ((busy_b || exp_b.size() != 0) && k < 300) begin
         tick();
         k++;
      end
      check(tag, exp_b.size() + int'(busy_b), 0);
   endtask

   // Output monitors: one line per accepted word, compared against the scoreboards.
   logic [3:0] prev_pop_a = '0;
   logic [2:0] prev_pop_b = '0;

   always @(negedge clk) begin : mon
      txn_t t;
      if (rst_n && bus_a.o_valid && bus_a.i_ready) begin
         $display("A word: ch=%0d data=%h", bus_a.o_ch, bus_a.o_data);
         check("a_sb_has_entry", int'(exp_a.size() > 0), 1);
         if (exp_a.size() > 0) begin
            t = exp_a.pop_front();
            check("a_out_ch", int'(bus_a.o_ch), int'(t.ch));
            check("a_out_data", int'(bus_a.o_data), int'(t.data));
         end
      end
      if (rst_n && bus_b.o_valid && bus_b.i_ready) begin
         $display("B word: ch=%0d data=%h", bus_b.o_ch, bus_b.o_data);
         check("b_sb_has_entry", int'(exp_b.size() > 0), 1);
         if (exp_b.size() > 0) begin
            t = exp_b.pop_front();
            check("b_out_ch", int'(bus_b.o_ch), int'(t.ch));
            check("b_out_data", int'(bus_b.o_data), int'(t.data));
         end
      end
      if (bus_a.o_pop != 4'b0) begin
         check("a_pop_onehot", int'($onehot(bus_a.o_pop)), 1);
         check("a_pop_gap", int'(prev_pop_a), 0);
      end
      if (bus_b.o_pop != 3'b0) begin
         check("b_pop_onehot", int'($onehot(bus_b.o_pop)), 1);
         check("b_pop_gap", int'(prev_pop_b), 0);
      end
      prev_pop_a <= bus_a.o_pop;
      prev_pop_b <= bus_b.o_pop;
   end

   initial begin : stim
      vec_t vecs [5];
      int   lat;

      vecs[0] = '{0, 16'h1111, 0, 0, 16'h1111, 3};
      vecs[1] = '{3, 16'h3333, 2, 3, 16'h3333, 3};
      vecs[2] = '{1, 16'h1234, 5, 1, 16'h1234, 3};
      vecs[3] = '{2, 16'hBEEF, 0, 2, 16'hBEEF, 3};
      vecs[4] = '{3, 16'hFFFF, 1, 3, 16'hFFFF, 3};

      rst_n = 1'b0;
      en_a  = 1'b0;
      en_b  = 1'b0;
      bus_a.i_ready = 1'b0;
      bus_b.i_ready = 1'b0;
      repeat (3) tick();

      check("reset_a_valid", int'(bus_a.o_valid), 0);
      check("reset_a_pop",   int'(bus_a.o_pop), 0);
      check("reset_a_busy",  int'(busy_a), 0);
      check("reset_a_data",  int'(bus_a.o_data), 0);
      check("reset_a_ch",    int'(bus_a.o_ch), 0);
      check("reset_b_valid", int'(bus_b.o_valid), 0);
      check("reset_b_busy",  int'(busy_b), 0);

      rst_n = 1'b1;
      en_a  = 1'b1;
      tick();

      // Single-word vectors: latency, hold under backpressure, delivery.
      for (int i = 0; i < 5; i++) begin
         bus_a.i_ready = (vecs[i].delay == 0);
         load_a(vecs[i].ch, int'(vecs[i].data));
         exp_a.push_back(mk(vecs[i].exp_ch, int'(vecs[i].exp_data)));
         wait_valid_a(lat);
         check("vec_latency", lat, vecs[i].exp_lat);
         for (int d = 0; d < vecs[i].delay; d++) begin
            check("vec_hold_data", int'(bus_a.o_data), int'(vecs[i].exp_data));
            check("vec_hold_ch",   int'(bus_a.o_ch), vecs[i].exp_ch);
            check("vec_hold_nopop", int'(bus_a.o_pop), 0);
            tick();
         end
         bus_a.i_ready = 1'b1;
         wait_idle_a("vec_drain");
      end

      // Single channel, two words: pops one word per three cycles.
      load_a(2, 'hA001);
      load_a(2, 'hA002);
      exp_a.push_back(mk(2, 'hA001));
      exp_a.push_back(mk(2, 'hA002));
      for (int t = 1; t <= 6; t++) begin
         tick();
         check("single_pop_timing", int'(bus_a.o_pop), (t == 1 || t == 4) ? 'b0100 : 0);
      end
      wait_idle_a("single_drain");
      // Pointer should now be 3: ch3 wins over ch0.
      load_a(0, 'h0C00);
      load_a(3, 'h3C00);
      exp_a.push_back(mk(3, 'h3C00));
      exp_a.push_back(mk(0, 'h0C00));
      wait_idle_a("ptr3_drain");

      // Reset while presenting: in-flight word 0x3001 is dropped.
      bus_a.i_ready = 1'b0;
      for (int i = 1; i <= 3; i++) load_a(3, 'h3000 + i);
      wait_valid_a(lat);
      check("rst_pre_valid", int'(bus_a.o_valid), 1);
      check("rst_pre_data",  int'(bus_a.o_data), 'h3001);
      rst_n = 1'b0;
      tick();
      check("rst_valid", int'(bus_a.o_valid), 0);
      check("rst_pop",   int'(bus_a.o_pop), 0);
      check("rst_busy",  int'(busy_a), 0);
      check("rst_data",  int'(bus_a.o_data), 0);
      load_a(0, 'h0A0A);
      exp_a.push_back(mk(0, 'h0A0A));
      exp_a.push_back(mk(3, 'h3002));
      exp_a.push_back(mk(3, 'h3003));
      rst_n = 1'b1;
      bus_a.i_ready = 1'b1;
      tick();
      check("rst_first_grant", int'(bus_a.o_pop), 'b0001);
      wait_idle_a("rst_drain");

      // Burst limit and rotation between ch0 and ch1.
      for (int i = 0; i < 6; i++) begin
         load_a(0, 'h0100 + i);
         load_a(1, 'h1100 + i);
      end
      for (int i = 0; i < 4; i++) exp_a.push_back(mk(0, 'h0100 + i));
      for (int i = 0; i < 4; i++) exp_a.push_back(mk(1, 'h1100 + i));
      for (int i = 4; i < 6; i++) exp_a.push_back(mk(0, 'h0100 + i));
      for (int i = 4; i < 6; i++) exp_a.push_back(mk(1, 'h1100 + i));
      wait_idle_a("burst_drain");

      // Backpressure then a follow-on pop one cycle after acceptance.
      bus_a.i_ready = 1'b0;
      load_a(1, 'h1234);
      load_a(1, 'h5678);
      exp_a.push_back(mk(1, 'h1234));
      exp_a.push_back(mk(1, 'h5678));
      wait_valid_a(lat);
      check("bp_latency", lat, 3);
      for (int d = 0; d < 5; d++) begin
         check("bp_hold_data", int'(bus_a.o_data), 'h1234);
         check("bp_hold_ch",   int'(bus_a.o_ch), 1);
         check("bp_no_pop",    int'(bus_a.o_pop), 0);
         tick();
      end
      bus_a.i_ready = 1'b1;
      tick();
      check("bp_next_pop", int'(bus_a.o_pop), 'b0010);
      wait_idle_a("bp_drain");

      // Enable drop during CAPTURE of ch1 word 2.
      for (int i = 1; i <= 4; i++) load_a(1, 'h1A00 + i);
      exp_a.push_back(mk(1, 'h1A01));
      exp_a.push_back(mk(1, 'h1A02));
      for (int t = 1; t <= 5; t++) begin
         tick();
         if (t == 4) check("en_word2_pop", int'(bus_a.o_pop), 'b0010);
      end
      en_a = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         check("en_no_pop", int'(bus_a.o_pop), 0);
      end
      check("en_idle", int'(busy_a), 0);
      check("en_word2_done", exp_a.size(), 0);
      load_a(0, 'h0D0D);
      exp_a.push_back(mk(0, 'h0D0D));
      exp_a.push_back(mk(1, 'h1A03));
      exp_a.push_back(mk(1, 'h1A04));
      en_a = 1'b1;
      wait_idle_a("en_resume_drain");

      // Three channels, burst 1: set pointer to 2, then check wrap order.
      en_b = 1'b1;
      bus_b.i_ready = 1'b1;
      load_b(1, 'hB100);
      exp_b.push_back(mk(1, 'hB100));
      wait_idle_b("wrap_setup");
      load_b(2, 'hB201);
      load_b(2, 'hB202);
      load_b(0, 'hB001);
      load_b(0, 'hB002);
      load_b(1, 'hB101);
      exp_b.push_back(mk(2, 'hB201));
      exp_b.push_back(mk(0, 'hB001));
      exp_b.push_back(mk(1, 'hB101));
      exp_b.push_back(mk(2, 'hB202));
      exp_b.push_back(mk(0, 'hB002));
      wait_idle_b("wrap_drain");

      repeat (3) tick();
      check("end_sb_a_empty", exp_a.size(), 0);
      check("end_sb_b_empty", exp_b.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_rr_drain_scheduler.md
Name: fifo_rr_drain_scheduler

Overview:
- Round-robin read scheduler that shares one downstream datapath/mux port between NUM_CH channel FIFOs.
- Watches each FIFO's empty flag and issues single-cycle pop pulses. Captures the registered FIFO output and presents it downstream with a valid/ready handshake.
- Grants up to BURST_MAX consecutive words per channel before rotating. Sits between the channel FIFO bank and the output mux.

Parameters:
- NUM_CH, 4, number of channel FIFOs (2..16; need not be a power of 2)
- DATA_W, 16, FIFO word width
- BURST_MAX, 4, maximum words drained from one channel per grant (>=1)
- CH_W, 2, width of channel index, equal to clog2(NUM_CH)
- BCNT_W, 3, width of burst counter, equal to clog2(BURST_MAX+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- i_enable  in  1  scheduler enable; when low, no new grant is started
- i_empty  in  NUM_CH  per-channel FIFO empty flags
- i_data  in  NUM_CH*DATA_W  per-channel FIFO read data; channel k at bits [k*DATA_W +: DATA_W], valid 1 cycle after pop
- o_pop  out  NUM_CH  one-hot pop strobe, at most one bit high per cycle
- o_data  out  DATA_W  word presented downstream
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts when o_valid & i_ready
- o_ch  out  CH_W  channel index of the word on o_data
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE, rr_ptr=0, grant=0, burst_cnt=0
  - o_pop=0, o_valid=0, o_data=0, o_ch=0
  - Reset mid-operation discards any in-flight word. A pop already issued is not replayed; the word is lost by design.
- States:
  - IDLE: if i_enable and any ~i_empty, choose grant = first non-empty channel searching rr_ptr, rr_ptr+1, ... mod NUM_CH. Then set burst_cnt=0 and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: o_pop[grant]=1 for exactly this cycle, then go to CAPTURE. Re-check ~i_empty[grant]; if the channel is empty (it should not be), issue no pop and return to IDLE.
  - CAPTURE: register o_data <= i_data[grant], o_ch <= grant, o_valid <= 1, burst_cnt <= burst_cnt+1. Go to PRESENT.
  - PRESENT: hold o_data/o_ch/o_valid stable while ~i_ready. On handshake, clear o_valid. Then:
    - if burst_cnt < BURST_MAX and ~i_empty[grant] and i_enable: go to ISSUE for the same grant
    - else: rr_ptr <= (grant+1) mod NUM_CH, then go to IDLE
- Latency:
  - IDLE with non-empty channel to o_valid high: 3 cycles (ISSUE, CAPTURE, then o_valid visible).
  - Steady burst with i_ready=1: one word per 3 cycles.
- The i_empty evaluation in PRESENT reflects the FIFO state after the previous pop (pop issued 2 cycles earlier). No extra guard is needed.
- Rotation:
  - rr_ptr advances only when a grant ends, to grant+1. It wraps explicitly when grant==NUM_CH-1 (no power-of-2 truncation).
  - Starvation bound: any non-empty channel is served within (NUM_CH-1)*BURST_MAX words.
- Simultaneous events:
  - i_enable dropping in ISSUE/CAPTURE/PRESENT does not abort; the current word completes, then the scheduler goes to IDLE with rr_ptr advanced.
  - Channel becoming non-empty during another grant waits its turn.
  - All channels empty in IDLE: no activity, o_pop=0.
- o_pop is a registered-free decode of state==ISSUE, one-hot on grant. It is never asserted in two consecutive cycles.

Decomposition:
- Shared package fifo_sched_pkg:
  - state enum (IDLE, ISSUE, CAPTURE, PRESENT), 2 bits
  - default NUM_CH/DATA_W/BURST_MAX constants
- Sub-module rr_pick: purely combinational, NUM_CH-parameterised.
  - Inputs: request vector, rr_ptr.
  - Outputs: grant index, any_req.
  - Rotate-and-priority-encode, with wrap handled for non-power-of-2 NUM_CH.

Test Plan:
- Reset mid-burst: assert rst_n=0 while in PRESENT with o_valid=1 -> next cycle o_valid=0, o_pop=0, o_busy=0; after release, first grant goes to channel 0.
- Single channel: ch2 holds 0xA001, 0xA002, all others empty, i_ready=1 -> o_pop[2] at cycles 1 and 4; o_data=0xA001/o_ch=2 then 0xA002/o_ch=2; ends in IDLE with rr_ptr=3.
- Burst limit and rotation: NUM_CH=4, BURST_MAX=4, ch0 and ch1 each hold 6 words -> output channel sequence 0,0,0,0,1,1,1,1,0,0,1,1.
- Backpressure: i_ready=0 for 5 cycles after o_valid rises with 0x1234 -> o_data=0x1234 and o_ch stable, no o_pop asserted; word accepted on i_ready=1, next pop follows 1 cycle later.
- Wrap on non-power-of-2: NUM_CH=3, BURST_MAX=1, all channels full, start with rr_ptr=2 -> grant order 2,0,1,2,0.
- Enable drop: deassert i_enable during CAPTURE of ch1 word 2 of 4 -> that word completes; no further pops; IDLE with rr_ptr=2; re-enable resumes at the next non-empty channel from 2.
